// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   MIPS pipeline decode stage. It contains the IF/ID pipeline register, the
//   32x32 register file with write-through bypass, the main/ALU control
//   decoder and the early branch/jump resolver. It feeds PC selection back to
//   fetch and the decoded fields to the ID/EX register.
//
// Ports
//   CLK, Reset               clock, synchronous active-high reset
//   InstrF, PcPlus4F         fetched instruction and its PC+4
//   StallD, FlushD           hazard unit hold / bubble-insert for IF/ID
//   RegWriteW, WriteRegW,
//   ResultW                  writeback port into the register file
//   ForwardAD, ForwardBD,
//   ALUOutM                  forwarding of the memory-stage result into the
//                            branch comparator
//   PcScrD                   fetch PC select (00 PC+4, 01 branch, 10 jump)
//   PcBranchD, PcJumpD       branch and jump targets
//   RD1D, RD2D               register data for rs / rt
//   RsD, RtD, RdD, SignImmD  instruction fields
//   RegWriteD .. BranchD,
//   ALUControlD              control signals for later stages
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      InstrF,
  input  logic [WIDTH-1:0] PcPlus4F,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             ForwardAD,
  input  logic             ForwardBD,
  input  logic [WIDTH-1:0] ALUOutM,
  output logic [1:0]       PcScrD,
  output logic [WIDTH-1:0] PcBranchD,
  output logic [WIDTH-1:0] PcJumpD,
  output logic [WIDTH-1:0] RD1D,
  output logic [WIDTH-1:0] RD2D,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic [4:0]       RdD,
  output logic [WIDTH-1:0] SignImmD,
  output logic             RegWriteD,
  output logic             MemtoRegD,
  output logic             MemWriteD,
  output logic             ALUSrcD,
  output logic             RegDstD,
  output logic             BranchD,
  output logic [2:0]       ALUControlD
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0]      instrD;
  logic [WIDTH-1:0] pcPlus4D;
  logic [WIDTH-1:0] regFile [32];
  logic             jumpD;
  logic             equalD;
  logic [WIDTH-1:0] branchA;
  logic [WIDTH-1:0] branchB;
  logic [5:0]       opcode;
  logic [5:0]       funct;

  // IF/ID register: reset beats flush beats stall.
  always_ff @(posedge CLK) begin
    if (Reset || FlushD) begin
      instrD   <= RESET_INSTR;
      pcPlus4D <= '0;
    end else if (!StallD) begin
      instrD   <= InstrF;
      pcPlus4D <= PcPlus4F;
    end
  end

  // Register file. Entry 0 is cleared on reset but never read back, since
  // address 0 is hard-wired to zero on the read side.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regFile[i] <= '0;
      end
    end else if (RegWriteW && (WriteRegW != 5'd0)) begin
      regFile[WriteRegW] <= ResultW;
    end
  end

  assign RsD      = instrD[25:21];
  assign RtD      = instrD[20:16];
  assign RdD      = instrD[15:11];
  assign SignImmD = {{(WIDTH-16){instrD[15]}}, instrD[15:0]};
  assign opcode   = instrD[31:26];
  assign funct    = instrD[5:0];

  // Combinational reads with write-through, so a value written back this
  // cycle is visible to the instruction currently in decode.
  always_comb begin
    RD1D = regFile[RsD];
    RD2D = regFile[RtD];
    if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsD)) RD1D = ResultW;
    if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtD)) RD2D = ResultW;
    if (RsD == 5'd0) RD1D = '0;
    if (RtD == 5'd0) RD2D = '0;
  end

  // Main and ALU control decode; unknown encodings decode as a bubble.
  always_comb begin
    RegWriteD   = 1'b0;
    MemtoRegD   = 1'b0;
    MemWriteD   = 1'b0;
    ALUSrcD     = 1'b0;
    RegDstD     = 1'b0;
    BranchD     = 1'b0;
    ALUControlD = 3'b000;
    jumpD       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        RegWriteD = 1'b1;
        RegDstD   = 1'b1;
        case (funct)
          6'b100000: ALUControlD = ALU_ADD;
          6'b100010: ALUControlD = ALU_SUB;
          6'b100100: ALUControlD = ALU_AND;
          6'b100101: ALUControlD = ALU_OR;
          6'b101010: ALUControlD = ALU_SLT;
          default: begin
            // sll/NOP and anything unsupported must not write a register
            RegWriteD = 1'b0;
            RegDstD   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        RegWriteD   = 1'b1;
        MemtoRegD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = ALU_ADD;
      end
      OP_SW: begin
        MemWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = ALU_ADD;
      end
      OP_BEQ: begin
        BranchD     = 1'b1;
        ALUControlD = ALU_SUB;
      end
      OP_ADDI: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = ALU_ADD;
      end
      OP_J: jumpD = 1'b1;
      default: ;
    endcase
  end

  // Early branch resolution with forwarding from the memory stage.
  assign branchA   = ForwardAD ? ALUOutM : RD1D;
  assign branchB   = ForwardBD ? ALUOutM : RD2D;
  assign equalD    = (branchA == branchB);
  assign PcBranchD = pcPlus4D + {SignImmD[WIDTH-3:0], 2'b00};
  assign PcJumpD   = {pcPlus4D[WIDTH-1:WIDTH-4], instrD[25:0], 2'b00};

  // A stalled instruction may be looking at stale operands, so it never
  // redirects fetch.
  always_comb begin
    PcScrD = 2'b00;
    if (!StallD) begin
      if (BranchD && equalD) PcScrD = 2'b01;
      else if (jumpD)        PcScrD = 2'b10;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instrF, pcPlus4F;
  logic        stall, flush;
  logic        regWriteW;
  logic [4:0]  writeRegW;
  logic [31:0] resultW;
  logic        fwdA, fwdB;
  logic [31:0] aluOutM;

  logic [1:0]  pcScrD;
  logic [31:0] pcBranchD, pcJumpD, rd1D, rd2D, signImmD;
  logic [4:0]  rsD, rtD, rdD;
  logic        regWriteD, memtoRegD, memWriteD, aluSrcD, regDstD, branchD;
  logic [2:0]  aluControlD;

  decode_stage dut (
    .CLK(clk), .Reset(rst), .InstrF(instrF), .PcPlus4F(pcPlus4F),
    .StallD(stall), .FlushD(flush), .RegWriteW(regWriteW), .WriteRegW(writeRegW),
    .ResultW(resultW), .ForwardAD(fwdA), .ForwardBD(fwdB), .ALUOutM(aluOutM),
    .PcScrD(pcScrD), .PcBranchD(pcBranchD), .PcJumpD(pcJumpD),
    .RD1D(rd1D), .RD2D(rd2D), .RsD(rsD), .RtD(rtD), .RdD(rdD), .SignImmD(signImmD),
    .RegWriteD(regWriteD), .MemtoRegD(memtoRegD), .MemWriteD(memWriteD),
    .ALUSrcD(aluSrcD), .RegDstD(regDstD), .BranchD(branchD), .ALUControlD(aluControlD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pcScr;
    logic [31:0] pcBranch;
    logic [31:0] pcJump;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] signImm;
    logic [5:0]  ctl;   // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, Branch}
    logic [2:0]  alu;
  } outT;

  typedef enum {K_NONE, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_BEQ, K_ADDI, K_J} kindT;

  outT expQ[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // Reference state: pipeline register contents and architectural registers.
  logic [31:0] mInstr, mPc;
  logic [31:0] regM [32];
  bit          modelValid = 0;

  function automatic kindT classify(input logic [31:0] i);
    int op, fn;
    op = int'(i >> 26);
    fn = int'(i & 32'h3F);
    if (op == 0) begin
      if (fn == 32) return K_ADD;
      if (fn == 34) return K_SUB;
      if (fn == 36) return K_AND;
      if (fn == 37) return K_OR;
      if (fn == 42) return K_SLT;
      return K_NONE;
    end
    if (op == 35) return K_LW;
    if (op == 43) return K_SW;
    if (op == 4)  return K_BEQ;
    if (op == 8)  return K_ADDI;
    if (op == 2)  return K_J;
    return K_NONE;
  endfunction

  function automatic logic [31:0] readReg(input int a);
    if (a == 0) return 32'd0;
    if (regWriteW && int'(writeRegW) == a) return resultW;
    return regM[a];
  endfunction

  function automatic outT expectOut();
    outT  e;
    kindT k;
    int   s;
    logic [31:0] opA, opB;
    e = '0;
    k = classify(mInstr);
    e.rs = 5'((mInstr >> 21) & 31);
    e.rt = 5'((mInstr >> 16) & 31);
    e.rd = 5'((mInstr >> 11) & 31);
    s = int'(mInstr & 32'hFFFF);
    if (s >= 32768) s = s - 65536;
    e.signImm  = 32'(s);
    e.pcBranch = mPc + 32'(s * 4);
    e.pcJump   = (mPc & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) << 2);
    e.rd1 = readReg(int'(e.rs));
    e.rd2 = readReg(int'(e.rt));
    case (k)
      K_ADD:  begin e.ctl = 6'b100010; e.alu = 3'b010; end
      K_SUB:  begin e.ctl = 6'b100010; e.alu = 3'b110; end
      K_AND:  begin e.ctl = 6'b100010; e.alu = 3'b000; end
      K_OR:   begin e.ctl = 6'b100010; e.alu = 3'b001; end
      K_SLT:  begin e.ctl = 6'b100010; e.alu = 3'b111; end
      K_LW:   begin e.ctl = 6'b110100; e.alu = 3'b010; end
      K_SW:   begin e.ctl = 6'b001100; e.alu = 3'b010; end
      K_BEQ:  begin e.ctl = 6'b000001; e.alu = 3'b110; end
      K_ADDI: begin e.ctl = 6'b100100; e.alu = 3'b010; end
      default: begin e.ctl = 6'b000000; e.alu = 3'b000; end
    endcase
    opA = fwdA ? aluOutM : e.rd1;
    opB = fwdB ? aluOutM : e.rd2;
    if (stall)                              e.pcScr = 2'b00;
    else if (k == K_BEQ && opA == opB)      e.pcScr = 2'b01;
    else if (k == K_J)                      e.pcScr = 2'b10;
    else                                    e.pcScr = 2'b00;
    return e;
  endfunction

  // Queue this cycle's expectation, advance the model, then move to the next cycle.
  task automatic step();
    if (modelValid) expQ.push_back(expectOut());
    if (rst) begin
      foreach (regM[k]) regM[k] = 32'd0;
      mInstr = 32'd0;
      mPc = 32'd0;
      modelValid = 1;
    end else begin
      if (regWriteW && writeRegW != 5'd0) regM[writeRegW] = resultW;
      if (flush) begin
        mInstr = 32'd0;
        mPc = 32'd0;
      end else if (!stall) begin
        mInstr = instrF;
        mPc = pcPlus4F;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    rst = 0; stall = 0; flush = 0; regWriteW = 0; writeRegW = 0; resultW = 0;
    fwdA = 0; fwdB = 0; aluOutM = 0; instrF = 0; pcPlus4F = 0;
  endtask

  function automatic logic [31:0] randInstr();
    int fl[8];
    logic [31:0] rs, rt, rd, imm;
    fl = '{32, 34, 36, 37, 42, 0, 3, 39};
    rs  = 32'($urandom_range(0, 7));
    rt  = 32'($urandom_range(0, 7));
    rd  = 32'($urandom_range(0, 31));
    imm = 32'($urandom_range(0, 65535));
    case ($urandom_range(0, 9))
      0, 1: return (rs << 21) | (rt << 16) | (rd << 11) | 32'(fl[$urandom_range(0, 7)]);
      2:    return (32'd35 << 26) | (rs << 21) | (rt << 16) | imm;
      3:    return (32'd43 << 26) | (rs << 21) | (rt << 16) | imm;
      4, 5: return (32'd4 << 26) | (rs << 21) | (rt << 16) | imm;
      6:    return (32'd8 << 26) | (rs << 21) | (rt << 16) | imm;
      7:    return (32'd2 << 26) | (32'($urandom) & 32'h03FF_FFFF);
      8:    return 32'($urandom);
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every cycle the DUT presents a decode result; check it mid-cycle.
  always @(negedge clk) begin
    outT a, e;
    cyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = '{pcScrD, pcBranchD, pcJumpD, rd1D, rd2D, rsD, rtD, rdD, signImmD,
            {regWriteD, memtoRegD, memWriteD, aluSrcD, regDstD, branchD}, aluControlD};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL decode cyc %0d: got/want pcScr %b/%b br %h/%h jmp %h/%h rd1 %h/%h rd2 %h/%h rs %0d/%0d rt %0d/%0d rd %0d/%0d imm %h/%h ctl %b/%b alu %b/%b",
                 cyc, a.pcScr, e.pcScr, a.pcBranch, e.pcBranch, a.pcJump, e.pcJump,
                 a.rd1, e.rd1, a.rd2, e.rd2, a.rs, e.rs, a.rt, e.rt, a.rd, e.rd,
                 a.signImm, e.signImm, a.ctl, e.ctl, a.alu, e.alu);
      end else begin
        $display("[TB] cyc %0d ok pcScr=%b ctl=%b alu=%b rd1=%h rd2=%h", cyc, a.pcScr, a.ctl, a.alu, a.rd1, a.rd2);
      end
    end
  end

  initial begin
    defaults();
    rst = 1;
    step();
    rst = 1;
    step();

    // lw $t0,4($0)
    defaults(); instrF = 32'h8C08_0004; pcPlus4F = 32'h104; step();
    defaults(); step();

    // write-through to rs=9, then a dropped write to $0
    defaults(); instrF = (32'd9 << 21) | (32'd10 << 11) | 32'd32; step();
    defaults(); regWriteW = 1; writeRegW = 9; resultW = 32'hDEAD_BEEF; step();
    defaults(); regWriteW = 1; writeRegW = 0; resultW = 32'h1234_5678; step();
    defaults(); step();

    // beq $1,$2,-1 at PC+4 = 0x200
    defaults(); regWriteW = 1; writeRegW = 1; resultW = 5; step();
    defaults(); regWriteW = 1; writeRegW = 2; resultW = 5; instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; step();
    defaults(); instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; step();
    defaults(); instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; regWriteW = 1; writeRegW = 2; resultW = 6; step();
    defaults(); instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; step();
    defaults(); instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; fwdB = 1; aluOutM = 5; step();

    // j 0x0100000 at PC+4 = 0x40000010
    defaults(); instrF = 32'h0810_0000; pcPlus4F = 32'h4000_0010; step();
    defaults(); step();

    // stall with changing fetch input, then stall and flush together
    defaults(); instrF = 32'h0810_0000; pcPlus4F = 32'h4000_0010; step();
    for (int i = 0; i < 2; i++) begin
      defaults(); stall = 1; instrF = randInstr(); pcPlus4F = $urandom; step();
    end
    defaults(); stall = 1; flush = 1; instrF = randInstr(); step();
    defaults(); step();

    // reset while a beq sits in decode and a writeback is pending
    defaults(); instrF = 32'h1022_FFFF; pcPlus4F = 32'h200; step();
    defaults(); rst = 1; stall = 1; regWriteW = 1; writeRegW = 3; resultW = 32'h77; step();
    defaults(); instrF = (32'd3 << 21) | (32'd1 << 16) | 32'd32; step();
    defaults(); step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      defaults();
      instrF    = randInstr();
      pcPlus4F  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095)) << 2;
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      regWriteW = $urandom_range(0, 1) == 1;
      writeRegW = 5'($urandom_range(0, 7));
      resultW   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      fwdA      = ($urandom_range(0, 3) == 0);
      fwdB      = ($urandom_range(0, 3) == 0);
      aluOutM   = 32'($urandom_range(0, 3));
      step();
    end

    defaults();
    @(negedge clk);
    #1;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
